// File: rtl/aurora_bist_checker_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aurora_bist_checker_if
// Purpose  : Receive-stream bundle between the Aurora PHY RX AXI4-Stream
//            output and the BIST checker. There is no backpressure, so the
//            bundle carries only data and valid.
// Signals  : i_tdata  [63:0] received word
//            i_tvalid        word valid; every valid word is consumed
// Modports : master (PHY side, drives), slave (checker side, samples)
// Revision : 1.0 - initial release
// ============================================================================
interface aurora_bist_checker_if;
  logic [63:0] i_tdata;
  logic        i_tvalid;

  modport master (output i_tdata, output i_tvalid);
  modport slave  (input  i_tdata, input  i_tvalid);
endinterface
`default_nettype wire

// File: rtl/aurora_bist_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aurora_bist_checker
// Purpose  : Receive-side PRBS BIST checker. Self-synchronises to the far-end
//            PRBS generator, then counts checked words and word errors.
// Ports    : clk        user clock (all logic in this domain)
//            rst_n      asynchronous active-low reset
//            en         checker enable; low = idle and clear
//            rx         stream bundle (i_tdata / i_tvalid), slave modport
//            locked     checker is locked to the PRBS
//            samps      valid words checked while locked (saturating)
//            errors     mismatching words while locked (saturating)
//            err_pulse  one-cycle strobe per mismatching word while locked
// Revision : 1.0 - initial release
// ============================================================================
module aurora_bist_checker #(
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 8,
  parameter int CNT_W        = 48
) (
  input  wire                        clk,
  input  wire                        rst_n,
  input  wire                        en,
  aurora_bist_checker_if.slave       rx,
  output logic                       locked,
  output logic [CNT_W-1:0]           samps,
  output logic [CNT_W-1:0]           errors,
  output logic                       err_pulse
);

  // run only ever needs to reach the larger of the two thresholds
  localparam int c_RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int c_RUN_W   = $clog2(c_RUN_MAX + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Next PRBS word; the generator uses the same shift/feedback.
  function automatic logic [63:0] prbs_nxt(input logic [63:0] w);
    return {w[62:0], w[63] ^ w[62] ^ w[60] ^ w[59]};
  endfunction

  state_t              r_state,     w_state_nxt;
  logic [63:0]         r_exp,       w_exp_nxt;
  logic [c_RUN_W-1:0]  r_run,       w_run_nxt;
  logic                r_locked,    w_locked_nxt;
  logic [CNT_W-1:0]    r_samps,     w_samps_nxt;
  logic [CNT_W-1:0]    r_errors,    w_errors_nxt;
  logic                r_err_pulse, w_err_pulse_nxt;

  logic [c_RUN_W-1:0]  w_run_inc;
  logic                w_match;
  logic                w_zero;

  assign w_run_inc = r_run + c_RUN_W'(1);
  assign w_match   = (rx.i_tdata == r_exp);
  assign w_zero    = (rx.i_tdata == 64'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SEARCH;
      r_exp       <= 64'd0;
      r_run       <= '0;
      r_locked    <= 1'b0;
      r_samps     <= '0;
      r_errors    <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_exp       <= w_exp_nxt;
      r_run       <= w_run_nxt;
      r_locked    <= w_locked_nxt;
      r_samps     <= w_samps_nxt;
      r_errors    <= w_errors_nxt;
      r_err_pulse <= w_err_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_exp_nxt       = r_exp;
    w_run_nxt       = r_run;
    w_locked_nxt    = r_locked;
    w_samps_nxt     = r_samps;
    w_errors_nxt    = r_errors;
    w_err_pulse_nxt = 1'b0;

    if (!en) begin
      // Enable low behaves like reset, counters included.
      w_state_nxt  = ST_SEARCH;
      w_exp_nxt    = 64'd0;
      w_run_nxt    = '0;
      w_locked_nxt = 1'b0;
      w_samps_nxt  = '0;
      w_errors_nxt = '0;
    end else if (rx.i_tvalid) begin
      unique case (r_state)
        ST_SEARCH: begin
          // Zero is the LFSR lock-up word and can never seed the sequence.
          if (!w_zero) begin
            w_exp_nxt   = prbs_nxt(rx.i_tdata);
            w_run_nxt   = '0;
            w_state_nxt = ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          if (w_match) begin
            w_exp_nxt = prbs_nxt(r_exp);
            if (w_run_inc == c_RUN_W'(LOCK_COUNT)) begin
              w_state_nxt  = ST_LOCKED;
              w_locked_nxt = 1'b1;
              w_run_nxt    = '0;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end else if (w_zero) begin
            w_state_nxt = ST_SEARCH;
            w_run_nxt   = '0;
          end else begin
            // Reseed immediately rather than waste a word back in SEARCH.
            w_exp_nxt = prbs_nxt(rx.i_tdata);
            w_run_nxt = '0;
          end
        end

        ST_LOCKED: begin
          // Free-run the expected sequence so an isolated corrupt word
          // costs one error and never shifts alignment.
          w_exp_nxt = prbs_nxt(r_exp);
          if (r_samps != {CNT_W{1'b1}}) begin
            w_samps_nxt = r_samps + CNT_W'(1);
          end
          if (w_match) begin
            w_run_nxt = '0;
          end else begin
            w_err_pulse_nxt = 1'b1;
            if (r_errors != {CNT_W{1'b1}}) begin
              w_errors_nxt = r_errors + CNT_W'(1);
            end
            if (w_run_inc == c_RUN_W'(UNLOCK_COUNT)) begin
              w_state_nxt  = ST_SEARCH;
              w_locked_nxt = 1'b0;
              w_run_nxt    = '0;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end
        end

        default: begin
          w_state_nxt = ST_SEARCH;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  assign locked    = r_locked;
  assign samps     = r_samps;
  assign errors    = r_errors;
  assign err_pulse = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_aurora_bist_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aurora_bist_checker
// Purpose  : Self-checking bench for aurora_bist_checker. A behavioural model
//            pushes the expected registered outputs for every driven cycle
//            into a scoreboard queue; each scenario pops and compares them
//            after the clock edge, plus scenario-level totals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aurora_bist_checker;
  localparam int CNT_W        = 48;
  localparam int LOCK_COUNT   = 16;
  localparam int UNLOCK_COUNT = 8;

  typedef struct packed {
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] samps;
    logic [CNT_W-1:0] errors;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] samps;
  logic [CNT_W-1:0] errors;

  aurora_bist_checker_if rx ();

  aurora_bist_checker #(
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rx        (rx.slave),
    .locked    (locked),
    .samps     (samps),
    .errors    (errors),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  obs_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] g;          // far-end generator state (next word to send)

  // reference model state: 0 = search, 1 = verify, 2 = locked
  int          m_state;
  logic [63:0] m_exp;
  int          m_run;
  obs_t        m_out;

  function automatic logic [63:0] prbs(input logic [63:0] w);
    return {w[62:0], w[63] ^ w[62] ^ w[60] ^ w[59]};
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.locked    = locked;
    o.err_pulse = err_pulse;
    o.samps     = samps;
    o.errors    = errors;
    return o;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_exp   = 64'd0;
    m_run   = 0;
    m_out   = '0;
  endtask

  // Drive one cycle, update the model, push the expectation, then step to
  // #1 after the rising edge where the registered result is visible.
  task automatic step(input logic e, input logic v, input logic [63:0] d);
    en          = e;
    rx.i_tvalid = v;
    rx.i_tdata  = d;
    m_out.err_pulse = 1'b0;
    if (!e) begin
      model_reset();
    end else if (v) begin
      if (m_state == 0) begin
        if (d != 64'd0) begin
          m_exp = prbs(d); m_run = 0; m_state = 1;
        end
      end else if (m_state == 1) begin
        if (d == m_exp) begin
          m_exp = prbs(m_exp);
          m_run = m_run + 1;
          if (m_run == LOCK_COUNT) begin
            m_state = 2; m_out.locked = 1'b1; m_run = 0;
          end
        end else if (d == 64'd0) begin
          m_state = 0; m_run = 0;
        end else begin
          m_exp = prbs(d); m_run = 0;
        end
      end else begin
        if (m_out.samps != {CNT_W{1'b1}}) m_out.samps = m_out.samps + 1'b1;
        if (d == m_exp) begin
          m_run = 0;
        end else begin
          m_out.err_pulse = 1'b1;
          if (m_out.errors != {CNT_W{1'b1}}) m_out.errors = m_out.errors + 1'b1;
          m_run = m_run + 1;
          if (m_run == UNLOCK_COUNT) begin
            m_state = 0; m_out.locked = 1'b0; m_run = 0;
          end
        end
        m_exp = prbs(m_exp);
      end
    end
    sb.push_back(m_out);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst_n = 1'b0;
    en    = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      rx.i_tvalid = i[0];
      rx.i_tdata  = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      @(posedge clk); #1;
      o = cur();
      n_tests++;
      if (o !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d] got %h want 0", i, o);
      end
    end
    rst_n = 1'b1;
    g = 64'h1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, g);
      g = prbs(g);
      e = sb.pop_front(); o = cur();
      n_tests++;
      if (o !== e || o !== '0) begin
        n_fail++;
        $display("FAIL en_low[%0d] got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_clean_lock();
    obs_t o, e;
    int lock_at = -1;
    g = 64'h1;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, g);
      g = prbs(g);
      e = sb.pop_front(); o = cur();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL clean_lock[%0d] got %h want %h", i, o, e);
      end
      if (o.locked && lock_at < 0) lock_at = i + 1;
    end
    n_tests++;
    if (lock_at !== 17 || samps !== 48'd83 || errors !== 48'd0) begin
      n_fail++;
      $display("FAIL clean_lock_totals got lock_word=%0d samps=%0d errors=%0d want 17/83/0",
               lock_at, samps, errors);
    end
  endtask

  task automatic test_single_error();
    obs_t o, e;
    logic [CNT_W-1:0] s0, e0;
    int pulses = 0;
    int dropped = 0;
    s0 = samps; e0 = errors;
    for (int i = 0; i < 51; i++) begin
      step(1'b1, 1'b1, (i == 0) ? (g ^ 64'h20) : g);
      g = prbs(g);
      e = sb.pop_front(); o = cur();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single_err[%0d] got %h want %h", i, o, e);
      end
      if (o.err_pulse) pulses++;
      if (!o.locked) dropped++;
    end
    n_tests++;
    if (errors !== e0 + 1 || samps !== s0 + 51 || pulses != 1 || dropped != 0) begin
      n_fail++;
      $display("FAIL single_err_totals got derr=%0d dsamps=%0d pulses=%0d unlocked=%0d want 1/51/1/0",
               errors - e0, samps - s0, pulses, dropped);
    end
  endtask

  task automatic test_loss_of_lock();
    obs_t o, e;
    logic [CNT_W-1:0] s0, e0;
    int fall_at = -1;
    int lock_at = -1;
    s0 = samps; e0 = errors;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, g ^ 64'h8000_0000_0000_0001);
      g = prbs(g);
      e = sb.pop_front(); o = cur();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL loss[%0d] got %h want %h", i, o, e);
      end
      if (!o.locked && fall_at < 0) fall_at = i + 1;
    end
    n_tests++;
    if (fall_at != 8 || errors !== e0 + 8 || samps !== s0 + 8) begin
      n_fail++;
      $display("FAIL loss_totals got fall_word=%0d derr=%0d dsamps=%0d want 8/8/8",
               fall_at, errors - e0, samps - s0);
    end
    s0 = samps; e0 = errors;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, g);
      g = prbs(g);
      e = sb.pop_front(); o = cur();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL relock[%0d] got %h want %h", i, o, e);
      end
      if (o.locked && lock_at < 0) begin
        lock_at = i + 1;
        n_tests++;
        if (samps !== s0 || errors !== e0) begin
          n_fail++;
          $display("FAIL relock_hold got samps=%0d errors=%0d want %0d/%0d", samps, errors, s0, e0);
        end
      end
    end
    n_tests++;
    if (lock_at != 17) begin
      n_fail++;
      $display("FAIL relock_word got %0d want 17", lock_at);
    end
  endtask

  task automatic test_gaps_zeros();
    obs_t o, e, prev;
    int nvalid = 0;
    int lock_at = -1;
    logic v;
    step(1'b0, 1'b0, 64'd0);
    e = sb.pop_front(); o = cur();
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL gaps_clear got %h want %h", o, e);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 64'd0);
      e = sb.pop_front(); o = cur();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL zeros[%0d] got %h want %h", i, o, e);
      end
    end
    prev = cur();
    for (int i = 0; i < 120; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        step(1'b1, 1'b1, g);
        g = prbs(g);
        nvalid++;
      end else begin
        step(1'b1, 1'b0, {$urandom, $urandom});
      end
      e = sb.pop_front(); o = cur();
      n_tests++;
      if (o !== e || (!v && (o.samps !== prev.samps || o.errors !== prev.errors || o.err_pulse))) begin
        n_fail++;
        $display("FAIL gaps[%0d] valid=%b got %h want %h", i, v, o, e);
      end
      if (o.locked && lock_at < 0) lock_at = nvalid;
      prev = o;
    end
    n_tests++;
    if (lock_at != 17) begin
      n_fail++;
      $display("FAIL gaps_lock_word got %0d want 17", lock_at);
    end
  endtask

  task automatic test_mid_run_clear();
    obs_t o, e;
    int lock_at;
    int guard;
    for (int pass = 0; pass < 2; pass++) begin
      guard = 0;
      while (samps < 100 && guard < 300) begin
        step(1'b1, 1'b1, g);
        g = prbs(g);
        guard++;
        e = sb.pop_front(); o = cur();
        n_tests++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL accum%0d[%0d] got %h want %h", pass, guard, o, e);
        end
      end
      n_tests++;
      if (samps < 100 || !locked) begin
        n_fail++;
        $display("FAIL accum%0d_bound got samps=%0d locked=%b want >=100/1", pass, samps, locked);
      end
      if (pass == 0) begin
        step(1'b0, 1'b1, g);
        g = prbs(g);
        e = sb.pop_front(); o = cur();
        n_tests++;
        if (o !== '0 || o !== e) begin
          n_fail++;
          $display("FAIL en_drop got %h want 0", o);
        end
      end else begin
        rx.i_tvalid = 1'b1;
        rx.i_tdata  = g;
        en          = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        o = cur();
        n_tests++;
        if (o !== '0) begin
          n_fail++;
          $display("FAIL async_rst got %h want 0", o);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      lock_at = -1;
      for (int i = 0; i < 20; i++) begin
        step(1'b1, 1'b1, g);
        g = prbs(g);
        e = sb.pop_front(); o = cur();
        n_tests++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL restart%0d[%0d] got %h want %h", pass, i, o, e);
        end
        if (o.locked && lock_at < 0) lock_at = i + 1;
      end
      n_tests++;
      if (lock_at != 17 || samps !== 48'd3) begin
        n_fail++;
        $display("FAIL restart%0d_totals got lock_word=%0d samps=%0d want 17/3", pass, lock_at, samps);
      end
    end
  endtask

  initial begin
    rx.i_tvalid = 1'b0;
    rx.i_tdata  = 64'd0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_gaps_zeros();
    test_mid_run_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
